// File: rtl/td4_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : td4_fetch_sequencer
//  Description : Fetch/decode sequencer for the TD4 4-bit CPU. Each
//                instruction is fetched from program ROM via a req/ack
//                handshake while the PC is held, then executed in a single
//                cycle that pulses the register-file loads, selects the adder
//                source and either advances the PC or loads a jump target.
//                Owns the carry flag consumed by JNC.
//  Ports       :
//    clk, rst_n          clock (rising edge), async active-low reset
//    pc_addr             current PC value
//    pc_in, pc_load      PC load interface (0 = load pc_in, 1 = increment)
//    rom_req, rom_addr   fetch request and address (rom_addr = pc_addr)
//    rom_ack, rom_data   fetch completion and instruction word {op, imm}
//    alu_carry           adder carry-out, sampled in EXEC by ADD opcodes
//    mux_sel, imm        adder source select and immediate operand
//    ld_a, ld_b, ld_out  one-cycle register load pulses (EXEC only)
//    carry_q             registered carry flag
//    illegal_op          one-cycle pulse for an undefined opcode
//  Revision    : 1.0 - initial release
// ============================================================================
module td4_fetch_sequencer #(
  parameter int ADDR_W = 4,
  parameter int OP_W   = 4,
  parameter int IMM_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic [ADDR_W-1:0] pc_in,
  output logic              pc_load,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [7:0]        rom_data,
  input  logic              alu_carry,
  output logic [1:0]        mux_sel,
  output logic [IMM_W-1:0]  imm,
  output logic              ld_a,
  output logic              ld_b,
  output logic              ld_out,
  output logic              carry_q,
  output logic              illegal_op
);

  localparam logic [0:0] c_ST_FETCH = 1'b0;
  localparam logic [0:0] c_ST_EXEC  = 1'b1;

  localparam logic [OP_W-1:0] c_OP_ADD_A  = OP_W'(4'h0);
  localparam logic [OP_W-1:0] c_OP_MOV_AB = OP_W'(4'h1);
  localparam logic [OP_W-1:0] c_OP_IN_A   = OP_W'(4'h2);
  localparam logic [OP_W-1:0] c_OP_MOV_AI = OP_W'(4'h3);
  localparam logic [OP_W-1:0] c_OP_MOV_BA = OP_W'(4'h4);
  localparam logic [OP_W-1:0] c_OP_ADD_B  = OP_W'(4'h5);
  localparam logic [OP_W-1:0] c_OP_IN_B   = OP_W'(4'h6);
  localparam logic [OP_W-1:0] c_OP_MOV_BI = OP_W'(4'h7);
  localparam logic [OP_W-1:0] c_OP_OUT_B  = OP_W'(4'h9);
  localparam logic [OP_W-1:0] c_OP_OUT_I  = OP_W'(4'hB);
  localparam logic [OP_W-1:0] c_OP_JNC    = OP_W'(4'hE);
  localparam logic [OP_W-1:0] c_OP_JMP    = OP_W'(4'hF);

  localparam logic [1:0] c_SEL_A    = 2'd0;
  localparam logic [1:0] c_SEL_B    = 2'd1;
  localparam logic [1:0] c_SEL_IN   = 2'd2;
  localparam logic [1:0] c_SEL_ZERO = 2'd3;

  logic [0:0]             r_state;
  logic [0:0]             w_next_state;
  logic [OP_W+IMM_W-1:0]  r_instr;
  logic                   r_carry;
  logic [OP_W-1:0]        w_op;
  logic [ADDR_W-1:0]      w_jump_target;
  logic                   w_is_add;

  assign w_op          = r_instr[OP_W+IMM_W-1:IMM_W];
  assign w_jump_target = ADDR_W'(r_instr[IMM_W-1:0]);
  assign w_is_add      = (w_op == c_OP_ADD_A) || (w_op == c_OP_ADD_B);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic: FETCH waits indefinitely for ack, EXEC lasts one cycle
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_FETCH: if (rom_ack) w_next_state = c_ST_EXEC;
      c_ST_EXEC:  w_next_state = c_ST_FETCH;
      default:    w_next_state = c_ST_FETCH;
    endcase
  end

  // --------------------------------------------------------------------------
  // Instruction latch and carry flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= '0;
      r_carry <= 1'b0;
    end else begin
      if (r_state == c_ST_FETCH && rom_ack) begin
        r_instr <= rom_data;
      end
      // Only ADDs keep a carry; everything else (JNC included, after it has
      // tested the old flag through the output logic) clears it.
      if (r_state == c_ST_EXEC) begin
        r_carry <= w_is_add ? alu_carry : 1'b0;
      end
    end
  end

  assign carry_q  = r_carry;
  assign rom_addr = pc_addr;
  assign imm      = r_instr[IMM_W-1:0];

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    // FETCH defaults: PC reloads its own value so it is held
    rom_req    = 1'b0;
    pc_load    = 1'b0;
    pc_in      = pc_addr;
    mux_sel    = c_SEL_ZERO;
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    ld_out     = 1'b0;
    illegal_op = 1'b0;
    case (r_state)
      c_ST_FETCH: begin
        rom_req = 1'b1;
      end
      c_ST_EXEC: begin
        pc_load = 1'b1;
        case (w_op)
          c_OP_ADD_A:  begin mux_sel = c_SEL_A;    ld_a   = 1'b1; end
          c_OP_MOV_AB: begin mux_sel = c_SEL_B;    ld_a   = 1'b1; end
          c_OP_IN_A:   begin mux_sel = c_SEL_IN;   ld_a   = 1'b1; end
          c_OP_MOV_AI: begin mux_sel = c_SEL_ZERO; ld_a   = 1'b1; end
          c_OP_MOV_BA: begin mux_sel = c_SEL_A;    ld_b   = 1'b1; end
          c_OP_ADD_B:  begin mux_sel = c_SEL_B;    ld_b   = 1'b1; end
          c_OP_IN_B:   begin mux_sel = c_SEL_IN;   ld_b   = 1'b1; end
          c_OP_MOV_BI: begin mux_sel = c_SEL_ZERO; ld_b   = 1'b1; end
          c_OP_OUT_B:  begin mux_sel = c_SEL_B;    ld_out = 1'b1; end
          c_OP_OUT_I:  begin mux_sel = c_SEL_ZERO; ld_out = 1'b1; end
          c_OP_JMP: begin
            pc_load = 1'b0;
            pc_in   = w_jump_target;
          end
          c_OP_JNC: begin
            if (!r_carry) begin
              pc_load = 1'b0;
              pc_in   = w_jump_target;
            end
          end
          default: illegal_op = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_td4_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_td4_fetch_sequencer
//  Description : Directed self-checking bench for td4_fetch_sequencer. The
//                bench plays the role of the PC (drives pc_addr) and the ROM.
//                Inputs change 1 ns after a rising edge; outputs are checked
//                at that point too, away from the active edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_td4_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pc_addr;
  logic [3:0] pc_in;
  logic       pc_load;
  logic       rom_req;
  logic [3:0] rom_addr;
  logic       rom_ack;
  logic [7:0] rom_data;
  logic       alu_carry;
  logic [1:0] mux_sel;
  logic [3:0] imm;
  logic       ld_a;
  logic       ld_b;
  logic       ld_out;
  logic       carry_q;
  logic       illegal_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  td4_fetch_sequencer #(.ADDR_W(4), .OP_W(4), .IMM_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr), .pc_in(pc_in),
    .pc_load(pc_load), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_ack(rom_ack), .rom_data(rom_data), .alu_carry(alu_carry),
    .mux_sel(mux_sel), .imm(imm), .ld_a(ld_a), .ld_b(ld_b),
    .ld_out(ld_out), .carry_q(carry_q), .illegal_op(illegal_op)
  );

  // Advance one cycle and land 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: present an instruction during FETCH with an optional ack
  // delay; returns positioned in the EXEC cycle of that instruction.
  task automatic issue(input logic [3:0] pc, input logic [7:0] data,
                       input int delay);
    pc_addr  = pc;
    rom_data = data;
    rom_ack  = 1'b0;
    repeat (delay) step();
    rom_ack = 1'b1;
    step();
    rom_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc_addr = 4'd0; rom_ack = 1'b0; rom_data = 8'h00;
    alu_carry = 1'b0;
    step(); step();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({rom_req, rom_addr, pc_load, pc_in, mux_sel} !== {1'b1, 4'd0, 1'b0, 4'd0, 2'd3}) begin
      errors++;
      $display("FAIL reset_fetch: req/addr/load/in/sel=%b/%0d/%b/%0d/%0d expected 1/0/0/0/3",
               rom_req, rom_addr, pc_load, pc_in, mux_sel);
    end
    checks++;
    if ({carry_q, ld_a, ld_b, ld_out, illegal_op} !== 5'b0) begin
      errors++;
      $display("FAIL reset_pulses: carry/lda/ldb/ldout/ill=%b expected 00000",
               {carry_q, ld_a, ld_b, ld_out, illegal_op});
    end
    step();
  endtask

  task automatic test_delayed_ack();
    int held = 0;
    pc_addr = 4'd0; rom_data = 8'h35; rom_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) rom_ack = 1'b1;
      #1;
      if (pc_load === 1'b0 && rom_req === 1'b1 && pc_in === 4'd0) held++;
      step();
      #0;
    end
    rom_ack = 1'b0;
    checks++;
    if (held !== 4) begin
      errors++;
      $display("FAIL delayed_hold: held cycles %0d expected 4", held);
    end
    checks++;
    if ({ld_a, ld_b, ld_out, mux_sel, imm, pc_load, rom_req} !== {1'b1, 1'b0, 1'b0, 2'd3, 4'd5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mov_a_imm_exec: lda/ldb/ldout/sel/imm/load/req=%b/%b/%b/%0d/%0d/%b/%b expected 1/0/0/3/5/1/0",
               ld_a, ld_b, ld_out, mux_sel, imm, pc_load, rom_req);
    end
    step();
    pc_addr = 4'd1;
    #1;
    checks++;
    if ({rom_req, rom_addr, ld_a} !== {1'b1, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL after_mov_fetch: req/addr/lda=%b/%0d/%b expected 1/1/0", rom_req, rom_addr, ld_a);
    end
  endtask

  task automatic test_jmp();
    issue(4'd1, 8'hF7, 0);
    checks++;
    if ({pc_load, pc_in, ld_a, ld_b, ld_out, illegal_op} !== {1'b0, 4'd7, 4'b0000}) begin
      errors++;
      $display("FAIL jmp_exec: load/in/lda/ldb/ldout/ill=%b/%0d/%b%b%b%b expected 0/7/0000",
               pc_load, pc_in, ld_a, ld_b, ld_out, illegal_op);
    end
    step();
    pc_addr = 4'd7;
    #1;
    checks++;
    if ({rom_req, rom_addr} !== {1'b1, 4'd7}) begin
      errors++;
      $display("FAIL jmp_target_fetch: req/addr=%b/%0d expected 1/7", rom_req, rom_addr);
    end
  endtask

  task automatic test_carry_jnc();
    issue(4'd7, 8'h01, 0);
    alu_carry = 1'b1;
    #1;
    checks++;
    if ({ld_a, mux_sel, pc_load} !== {1'b1, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL add_a_exec: lda/sel/load=%b/%0d/%b expected 1/0/1", ld_a, mux_sel, pc_load);
    end
    step();
    alu_carry = 1'b0;
    checks++;
    if (carry_q !== 1'b1) begin
      errors++;
      $display("FAIL add_sets_carry: carry_q=%b expected 1", carry_q);
    end
    // Carry set: JNC falls through and then clears the flag
    issue(4'd8, 8'hE3, 0);
    checks++;
    if ({pc_load, carry_q} !== 2'b11) begin
      errors++;
      $display("FAIL jnc_not_taken: load/carry=%b/%b expected 1/1", pc_load, carry_q);
    end
    step();
    checks++;
    if (carry_q !== 1'b0) begin
      errors++;
      $display("FAIL jnc_clears_carry: carry_q=%b expected 0", carry_q);
    end
    // Carry clear: JNC is taken
    issue(4'd9, 8'hE3, 0);
    checks++;
    if ({pc_load, pc_in} !== {1'b0, 4'd3}) begin
      errors++;
      $display("FAIL jnc_taken: load/in=%b/%0d expected 0/3", pc_load, pc_in);
    end
    step();
    // ADD B with no carry out leaves the flag clear
    issue(4'd3, 8'h52, 1);
    checks++;
    if ({ld_b, ld_a, mux_sel, imm} !== {1'b1, 1'b0, 2'd1, 4'd2}) begin
      errors++;
      $display("FAIL add_b_exec: ldb/lda/sel/imm=%b/%b/%0d/%0d expected 1/0/1/2", ld_b, ld_a, mux_sel, imm);
    end
    step();
  endtask

  task automatic test_out_wrap();
    issue(4'd15, 8'h94, 0);
    checks++;
    if ({ld_out, ld_a, ld_b, mux_sel, pc_load} !== {3'b100, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL out_b_exec: ldout/lda/ldb/sel/load=%b/%b/%b/%0d/%b expected 1/0/0/1/1",
               ld_out, ld_a, ld_b, mux_sel, pc_load);
    end
    step();
    pc_addr = 4'd0;
    #1;
    checks++;
    if ({rom_req, rom_addr, ld_out} !== {1'b1, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL wrap_fetch: req/addr/ldout=%b/%0d/%b expected 1/0/0", rom_req, rom_addr, ld_out);
    end
  endtask

  task automatic test_illegal_and_reset();
    issue(4'd0, 8'h80, 0);
    checks++;
    if ({illegal_op, ld_a, ld_b, ld_out, pc_load} !== 5'b10001) begin
      errors++;
      $display("FAIL illegal_exec: ill/lda/ldb/ldout/load=%b expected 10001",
               {illegal_op, ld_a, ld_b, ld_out, pc_load});
    end
    step();
    checks++;
    if ({illegal_op, rom_req} !== 2'b01) begin
      errors++;
      $display("FAIL illegal_one_cycle: ill/req=%b/%b expected 0/1", illegal_op, rom_req);
    end
    // Set the carry so reset clearing it is observable
    issue(4'd1, 8'h0F, 0);
    alu_carry = 1'b1;
    step();
    alu_carry = 1'b0;
    pc_addr = 4'd2; rom_data = 8'h35; rom_ack = 1'b0;
    step();
    #2;
    rst_n = 1'b0;          // asynchronous, mid-FETCH wait
    rom_ack = 1'b1;        // must be ignored while in reset
    #1;
    checks++;
    if ({carry_q, rom_req, ld_a, ld_b, ld_out, illegal_op} !== 6'b010000) begin
      errors++;
      $display("FAIL reset_mid_fetch: carry/req/pulses=%b expected 010000",
               {carry_q, rom_req, ld_a, ld_b, ld_out, illegal_op});
    end
    step();
    rom_ack = 1'b0;
    rst_n = 1'b1;
    step();
    checks++;
    if ({rom_req, rom_addr, pc_load, ld_a} !== {1'b1, 4'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL fetch_restart: req/addr/load/lda=%b/%0d/%b/%b expected 1/2/0/0",
               rom_req, rom_addr, pc_load, ld_a);
    end
    issue(4'd2, 8'h35, 0);
    checks++;
    if ({ld_a, imm} !== {1'b1, 4'd5}) begin
      errors++;
      $display("FAIL post_reset_exec: lda/imm=%b/%0d expected 1/5", ld_a, imm);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_delayed_ack();
    test_jmp();
    test_carry_jnc();
    test_out_wrap();
    test_illegal_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
